// File: rtl/rand_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rand_pkg                                                             |
// | Shared types and constants for the random range sampler.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } sampler_state_t;

    localparam int REJ_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/rand_range_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rand_range_sampler                                                   |
// | Rejection-samples serial random bits into OFFSET..OFFSET+RANGE-1.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rand_range_sampler
    import rand_pkg::*;
#(
    parameter int RANGE  = 6,
    parameter int OFFSET = 1,
    parameter int WIDTH  = $clog2(RANGE),
    parameter int OUT_W  = $clog2(OFFSET + RANGE)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RAND_BIT,
    input  logic                 REQ,
    output logic                 RAND_VALID,
    input  logic                 RAND_READY,
    output logic [OUT_W-1:0]     RAND_VAL,
    output logic                 BUSY,
    output logic [REJ_CNT_W-1:0] REJ_CNT
);

    localparam int                   c_CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [WIDTH:0]       c_RANGE_EXT = (WIDTH + 1)'(RANGE);
    localparam logic [OUT_W-1:0]     c_OFFSET    = OUT_W'(OFFSET);
    localparam logic [REJ_CNT_W-1:0] c_REJ_ONE   = REJ_CNT_W'(1);
    localparam logic [REJ_CNT_W-1:0] c_REJ_MAX   = '1;

    sampler_state_t         r_state;
    sampler_state_t         w_state_nxt;
    logic [WIDTH-1:0]       r_shift;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_valid;
    logic                   r_busy;
    logic [OUT_W-1:0]       r_val;
    logic [REJ_CNT_W-1:0]   r_rej_cnt;
    logic                   w_in_range;
    logic                   w_valid_nxt;
    logic                   w_busy_nxt;
    logic [OUT_W-1:0]       w_val_nxt;

    assign w_in_range = {1'b0, r_shift} < c_RANGE_EXT;
    assign w_val_nxt  = OUT_W'(r_shift) + c_OFFSET;

    // State register plus the datapath it steers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_val     <= '0;
            r_rej_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;

            // Counter idles at zero so every entry into FILL starts a fresh word
            if (r_state == FILL) begin
                r_shift <= WIDTH'({r_shift, RAND_BIT});
                r_cnt   <= r_cnt + c_CNT_ONE;
            end else begin
                r_cnt   <= '0;
            end

            if (r_state == CHECK) begin
                if (w_in_range) begin
                    r_val <= w_val_nxt;
                end else if (r_rej_cnt != c_REJ_MAX) begin
                    r_rej_cnt <= r_rej_cnt + c_REJ_ONE;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = REQ ? FILL : IDLE;
            FILL:    w_state_nxt = (r_cnt == c_CNT_LAST) ? CHECK : FILL;
            CHECK:   w_state_nxt = w_in_range ? HOLD : FILL;
            HOLD:    if (RAND_READY) w_state_nxt = REQ ? FILL : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered copies decoded from the next state
    always_comb begin
        w_valid_nxt = (w_state_nxt == HOLD);
        w_busy_nxt  = (w_state_nxt == FILL) || (w_state_nxt == CHECK);
    end

    assign RAND_VALID = r_valid;
    assign RAND_VAL   = r_val;
    assign BUSY       = r_busy;
    assign REJ_CNT    = r_rej_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rand_range_sampler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_rand_range_sampler                                                |
// | Table-driven and scoreboard bench for rand_range_sampler.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rand_range_sampler;
    import rand_pkg::*;

    localparam int RANGE  = 6;
    localparam int OFFSET = 1;
    localparam int WIDTH  = 3;
    localparam int OUT_W  = 3;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic                 RAND_BIT = 1'b0;
    logic                 REQ = 1'b0;
    logic                 RAND_READY = 1'b0;
    logic                 RAND_VALID;
    logic [OUT_W-1:0]     RAND_VAL;
    logic                 BUSY;
    logic [REJ_CNT_W-1:0] REJ_CNT;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [OUT_W-1:0] val;
        int               rej;
        int               lat;
    } exp_t;

    typedef struct {
        logic [11:0]      words;
        int               n;
        logic [OUT_W-1:0] exp_val;
        int               hold;
    } vec_t;

    exp_t             sb[$];
    int               rej_model = 0;
    logic [OUT_W-1:0] last_exp  = '0;
    vec_t             vecs[7];
    logic [2:0]       wq[$];
    logic [11:0]      wpack;
    logic [2:0]       rw;

    rand_range_sampler #(
        .RANGE  (RANGE),
        .OFFSET (OFFSET)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RAND_BIT   (RAND_BIT),
        .REQ        (REQ),
        .RAND_VALID (RAND_VALID),
        .RAND_READY (RAND_READY),
        .RAND_VAL   (RAND_VAL),
        .BUSY       (BUSY),
        .REJ_CNT    (REJ_CNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_req();
        REQ = 1'b1;
        cyc();
        REQ = 1'b0;
    endtask

    // Called just after the edge that takes a request; feeds the words
    // MSB-first with a don't-care bit in each CHECK slot.
    task automatic wait_result(input logic [2:0] q[$], input logic [OUT_W-1:0] exp_val,
                               input bit poke_req);
        exp_t e;
        exp_t x;
        int   n;
        int   idx;
        int   p;
        int   lat;
        bit   seen;
        n    = q.size();
        seen = 1'b0;
        lat  = 0;
        rej_model = (rej_model + n - 1 > 255) ? 255 : rej_model + n - 1;
        e.val = exp_val;
        e.rej = rej_model;
        e.lat = (WIDTH + 1) * n;
        sb.push_back(e);
        last_exp = exp_val;
        chk("busy_after_take", BUSY, 1);
        for (int c = 1; c <= (WIDTH + 1) * n + 8 && !seen; c++) begin
            idx = (c - 1) / (WIDTH + 1);
            p   = (c - 1) % (WIDTH + 1);
            if (idx < n && p < WIDTH) RAND_BIT = q[idx][WIDTH-1-p];
            else                      RAND_BIT = 1'($urandom);
            REQ = poke_req ? 1'($urandom) : 1'b0;
            cyc();
            if (RAND_VALID === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        REQ = 1'b0;
        chk("valid_seen", 32'(seen), 1);
        x = sb.pop_front();
        if (seen) begin
            chk("rand_val", 32'(RAND_VAL), 32'(x.val));
            chk("rej_cnt", 32'(REJ_CNT), x.rej);
            chk("latency", lat, x.lat);
            chk("busy_in_hold", BUSY, 0);
        end
    endtask

    task automatic handshake(input int hold, input bit chain);
        RAND_READY = 1'b0;
        for (int i = 0; i < hold; i++) begin
            RAND_BIT = ~RAND_BIT;
            REQ      = 1'($urandom);
            cyc();
            chk("hold_valid", RAND_VALID, 1);
            chk("hold_val", 32'(RAND_VAL), 32'(last_exp));
        end
        RAND_READY = 1'b1;
        REQ        = chain;
        cyc();
        RAND_READY = 1'b0;
        REQ        = 1'b0;
        chk("valid_after_accept", RAND_VALID, 0);
        chk("busy_after_accept", BUSY, 32'(chain));
    endtask

    task automatic idle_check(input int ncyc);
        RAND_READY = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            RAND_BIT = 1'($urandom);
            cyc();
            chk("idle_valid", RAND_VALID, 0);
            chk("idle_busy", BUSY, 0);
        end
        RAND_READY = 1'b0;
    endtask

    initial begin
        vecs[0] = '{12'b101_000_000_000, 1, 3'd6, 0};
        vecs[1] = '{12'b111_010_000_000, 2, 3'd3, 2};
        vecs[2] = '{12'b000_000_000_000, 1, 3'd1, 1};
        vecs[3] = '{12'b110_111_011_000, 3, 3'd4, 0};
        vecs[4] = '{12'b100_000_000_000, 1, 3'd5, 3};
        vecs[5] = '{12'b001_000_000_000, 1, 3'd2, 0};
        vecs[6] = '{12'b111_110_110_101, 4, 3'd6, 1};

        #1 RST = 1'b1;
        #1;
        chk("rst_valid", RAND_VALID, 0);
        chk("rst_val", 32'(RAND_VAL), 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_rej", 32'(REJ_CNT), 0);
        cyc();
        cyc();
        RST = 1'b0;
        idle_check(2);

        for (int i = 0; i < 7; i++) begin
            wpack = vecs[i].words;
            wq.delete();
            for (int j = 0; j < vecs[i].n; j++) wq.push_back(wpack[11-3*j -: 3]);
            start_req();
            wait_result(wq, vecs[i].exp_val, 1'b0);
            handshake(vecs[i].hold, 1'b0);
        end

        // Random words with an optional rejected prefix
        for (int i = 0; i < 4; i++) begin
            wq.delete();
            if ($urandom_range(0, 1) == 1) wq.push_back(3'($urandom_range(6, 7)));
            rw = 3'($urandom_range(0, 5));
            wq.push_back(rw);
            start_req();
            wait_result(wq, rw + 3'(OFFSET), 1'b0);
            handshake(0, 1'b0);
        end

        // Backpressure with a toggling bit stream
        wq.delete();
        wq.push_back(3'b010);
        start_req();
        wait_result(wq, 3'd3, 1'b0);
        handshake(10, 1'b0);
        idle_check(2);

        // Back-to-back request on the accepting edge
        wq.delete();
        wq.push_back(3'b100);
        start_req();
        wait_result(wq, 3'd5, 1'b0);
        handshake(0, 1'b1);
        wq.delete();
        wq.push_back(3'b000);
        wait_result(wq, 3'd1, 1'b0);
        handshake(0, 1'b0);

        // Reset in the middle of a fill
        start_req();
        RAND_BIT = 1'b0;
        cyc();
        RAND_BIT = 1'b1;
        cyc();
        #2 RST = 1'b1;
        #1;
        chk("midrst_valid", RAND_VALID, 0);
        chk("midrst_val", 32'(RAND_VAL), 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_rej", 32'(REJ_CNT), 0);
        cyc();
        RST = 1'b0;
        rej_model = 0;
        idle_check(1);
        wq.delete();
        wq.push_back(3'b011);
        start_req();
        wait_result(wq, 3'd4, 1'b0);
        handshake(1, 1'b0);

        // Saturate the reject counter while poking REQ during the fill
        wq.delete();
        for (int i = 0; i < 300; i++) wq.push_back(3'b111);
        wq.push_back(3'b000);
        start_req();
        wait_result(wq, 3'd1, 1'b1);
        handshake(0, 1'b0);
        idle_check(6);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rand_range_sampler.md
# rand_range_sampler

Downstream consumer of the serial random bit stream produced by the project's random serial generator. On request, it shifts in a fixed number of serial bits and forms an unsigned word. Words outside the configured range are rejected and refilled (rejection sampling). Each accepted value, plus an offset, is presented on a valid/ready handshake to game logic, for example a dice or target selector.

## Interface
- RANGE, 6: number of distinct output values; must be ≥ 2.
- OFFSET, 1: constant added to the accepted word; output spans OFFSET..OFFSET+RANGE-1.
- WIDTH, $clog2(RANGE): serial bits per candidate word (derived; not overridden).
- OUT_W, $clog2(OFFSET+RANGE): output value width (derived).

- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- RAND_BIT  in  1  serial random bit from the generator; a new bit is valid every cycle.
- REQ  in  1  request one value; sampled only in IDLE, or in HOLD on the accepting edge.
- RAND_VALID  out  1  RAND_VAL holds an accepted value.
- RAND_READY  in  1  consumer accepts the value when high together with RAND_VALID.
- RAND_VAL  out  OUT_W  accepted word + OFFSET.
- BUSY  out  1  high in FILL or CHECK.
- REJ_CNT  out  8  saturating count of rejected words since reset (debug).

## Operation
- States: IDLE, FILL, CHECK, HOLD.
- IDLE:
  - REQ=1 → FILL; clear the bit counter.
  - REQ=0 → stay in IDLE.
- FILL: each edge, shift RAND_BIT in at the LSB; the first received bit ends as the MSB. After WIDTH bits → CHECK.
- CHECK: one cycle, compares the word against RANGE.
  - word < RANGE: register RAND_VAL = word + OFFSET, set RAND_VALID, go to HOLD.
  - word ≥ RANGE: REJ_CNT += 1 (saturates at 255), clear the bit counter, go to FILL.
- HOLD: RAND_VALID=1; RAND_VAL stays stable until the handshake.
  - RAND_VALID && RAND_READY at an edge: RAND_VALID clears.
  - Next state is FILL if REQ=1 on that same edge, otherwise IDLE.
- REQ outside IDLE/HOLD-accept edges is ignored; requests are not queued.
- RAND_READY outside HOLD is ignored.
- Arithmetic:
  - Comparison is unsigned at WIDTH+1 bits.
  - The addition is done at OUT_W bits; no overflow is possible by construction.
- If RANGE is a power of two, no word is ever rejected.

## Timing
- Reset values:
  - state IDLE
  - RAND_VALID 0
  - RAND_VAL 0
  - BUSY 0
  - REJ_CNT 0
  - shift register and bit counter 0
- Reset asserted mid-operation: immediate return to the reset values. The partial word is discarded and REJ_CNT is cleared.
- REQ high at edge k in IDLE:
  - bits are sampled at edges k+1..k+WIDTH;
  - CHECK is evaluated at edge k+WIDTH+1;
  - RAND_VALID is high after edge k+WIDTH+1 at the earliest (latency WIDTH+1 cycles).
- Each rejection adds WIDTH+1 cycles.
- Handshake completes at an edge where RAND_VALID=1 and RAND_READY=1. RAND_VALID is low after that edge unless a later CHECK sets it again; the minimum gap is WIDTH+1 cycles.
- BUSY is registered from state; it is high from the edge after REQ is taken until the CHECK edge that accepts.
- Outputs are registered; no combinational path from RAND_READY or REQ to any output.

## Structure
- Package rand_pkg:
  - typedef enum logic [1:0] sampler_state_t {IDLE, FILL, CHECK, HOLD};
  - localparam REJ_CNT_W = 8.
- Single module; no sub-module required. The shift register, bit counter and FSM are small enough to keep inline.
- Intended top-level hookup: RAND_BIT ← RAND_OUT of the serial generator, sharing CLK.

## Test plan
All scenarios use RANGE=6, OFFSET=1, WIDTH=3.
- Accept on first fill: REQ pulse, bits 1,0,1 (word 5) → RAND_VALID after 4 cycles, RAND_VAL=6, REJ_CNT=0.
- Rejection then accept: bits 1,1,1 then 0,1,0 → REJ_CNT=1, RAND_VAL=3, RAND_VALID 8 cycles after REQ.
- Backpressure: RAND_READY low for 10 cycles in HOLD while RAND_BIT toggles → RAND_VAL and RAND_VALID are stable. RAND_READY=1 for one cycle → RAND_VALID=0 next cycle, state IDLE.
- Back-to-back: REQ=1 and RAND_READY=1 on the accept edge, next bits 0,0,0 → BUSY=1 immediately, new RAND_VAL=1 after 4 cycles.
- Reset mid-FILL: assert RST after 2 bits → all outputs 0 and state IDLE asynchronously. After release, a fresh REQ with bits 0,1,1 → RAND_VAL=4.
- Saturation and ignored REQ: force 300 rejections (all-ones stream) → REJ_CNT=255. REQ pulses during FILL produce no extra values.
